// File: rtl/id_ex_reg_pkg.sv
// Shared CPU package: field widths and the bubble control encoding used by the ID/EX register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_reg_pkg;

  localparam int RESULT_SRC_W = 2;
  localparam int ALU_SRC_A_W  = 2;
  localparam int ALU_CTRL_W   = 4;
  localparam int REG_ADDR_W   = 5;
  localparam int FUNCT3_W     = 3;
  localparam int BUBBLE_CNT_W = 32;

  // Decoder control word carried from ID into EX.
  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic                    jump;
    logic                    branch;
    logic                    alu_src_b;
    logic [RESULT_SRC_W-1:0] result_src;
    logic [ALU_SRC_A_W-1:0]  alu_src_a;
    logic [ALU_CTRL_W-1:0]   alu_control;
    logic [FUNCT3_W-1:0]     funct3;
  } ctrl_t;

  // A bubble is the all-zero control word: no register write, no memory write,
  // no jump/branch, so nothing downstream has a side effect.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Generic pipeline register slice with enable and synchronous clear.
// Latency: 1 cycle d->q.
// Backpressure: en=0 holds q; clr wins over en and loads zero.
//
// Ports: clk, rst_n (async active-low clear), en (load enable), clr (sync clear),
//        d (next value), q (registered value).
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoder controls, operands and PC values for EX.
// Latency: exactly 1 cycle D->E; every output is a flop, no input->output comb path.
// Backpressure: stall holds all E fields; flush loads a bubble (all zero, validE=0) and wins over stall.
//
// Ports: clk, rst_n (async active-low); stall, flush; *D decoder/operand inputs;
//        matching *E outputs; validE (EX holds a real instruction);
//        bubble_cnt (count of flush edges, wraps at 2^32).
// Optional feature: define ID_EX_PERF_CNT_EN to build the bubble counter;
//        otherwise bubble_cnt is tied to zero and has no flops.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    RegWriteD,
  input  logic                    MemWriteD,
  input  logic                    JumpD,
  input  logic                    BranchD,
  input  logic                    ALUSrcBD,
  input  logic [RESULT_SRC_W-1:0] ResultSrcD,
  input  logic [ALU_SRC_A_W-1:0]  ALUSrcAD,
  input  logic [ALU_CTRL_W-1:0]   ALUControlD,
  input  logic [XLEN-1:0]         RD1D,
  input  logic [XLEN-1:0]         RD2D,
  input  logic [XLEN-1:0]         ImmExtD,
  input  logic [XLEN-1:0]         PCD,
  input  logic [XLEN-1:0]         PCPlus4D,
  input  logic [REG_ADDR_W-1:0]   Rs1D,
  input  logic [REG_ADDR_W-1:0]   Rs2D,
  input  logic [REG_ADDR_W-1:0]   RdD,
  input  logic [FUNCT3_W-1:0]     funct3D,
  output logic                    RegWriteE,
  output logic                    MemWriteE,
  output logic                    JumpE,
  output logic                    BranchE,
  output logic                    ALUSrcBE,
  output logic [RESULT_SRC_W-1:0] ResultSrcE,
  output logic [ALU_SRC_A_W-1:0]  ALUSrcAE,
  output logic [ALU_CTRL_W-1:0]   ALUControlE,
  output logic [XLEN-1:0]         RD1E,
  output logic [XLEN-1:0]         RD2E,
  output logic [XLEN-1:0]         ImmExtE,
  output logic [XLEN-1:0]         PCE,
  output logic [XLEN-1:0]         PCPlus4E,
  output logic [REG_ADDR_W-1:0]   Rs1E,
  output logic [REG_ADDR_W-1:0]   Rs2E,
  output logic [REG_ADDR_W-1:0]   RdE,
  output logic [FUNCT3_W-1:0]     funct3E,
  output logic                    validE,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  logic  ld_en;
  ctrl_t ctrl_d;

  // Stall only gates the load; flush is handled as the slices' clear so it
  // overrides a simultaneous stall.
  assign ld_en = ~stall;

  // The control word presented to the slices is already the bubble encoding
  // during a flush, so controls never depend on clear/enable ordering alone.
  always_comb begin
    ctrl_d = CTRL_BUBBLE;
    if (!flush) begin
      ctrl_d.reg_write   = RegWriteD;
      ctrl_d.mem_write   = MemWriteD;
      ctrl_d.jump        = JumpD;
      ctrl_d.branch      = BranchD;
      ctrl_d.alu_src_b   = ALUSrcBD;
      ctrl_d.result_src  = ResultSrcD;
      ctrl_d.alu_src_a   = ALUSrcAD;
      ctrl_d.alu_control = ALUControlD;
      ctrl_d.funct3      = funct3D;
    end
  end

  // Control fields
  pipe_reg #(.WIDTH(1)) u_reg_write (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                     .d(ctrl_d.reg_write), .q(RegWriteE));
  pipe_reg #(.WIDTH(1)) u_mem_write (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                     .d(ctrl_d.mem_write), .q(MemWriteE));
  pipe_reg #(.WIDTH(1)) u_jump      (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                     .d(ctrl_d.jump), .q(JumpE));
  pipe_reg #(.WIDTH(1)) u_branch    (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                     .d(ctrl_d.branch), .q(BranchE));
  pipe_reg #(.WIDTH(1)) u_alu_src_b (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                     .d(ctrl_d.alu_src_b), .q(ALUSrcBE));
  pipe_reg #(.WIDTH(RESULT_SRC_W)) u_result_src (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                                 .d(ctrl_d.result_src), .q(ResultSrcE));
  pipe_reg #(.WIDTH(ALU_SRC_A_W)) u_alu_src_a (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                               .d(ctrl_d.alu_src_a), .q(ALUSrcAE));
  pipe_reg #(.WIDTH(ALU_CTRL_W)) u_alu_control (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                                .d(ctrl_d.alu_control), .q(ALUControlE));
  pipe_reg #(.WIDTH(FUNCT3_W)) u_funct3 (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                         .d(ctrl_d.funct3), .q(funct3E));

  // Operand and PC fields, captured verbatim
  pipe_reg #(.WIDTH(XLEN)) u_rd1     (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                      .d(RD1D), .q(RD1E));
  pipe_reg #(.WIDTH(XLEN)) u_rd2     (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                      .d(RD2D), .q(RD2E));
  pipe_reg #(.WIDTH(XLEN)) u_imm_ext (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                      .d(ImmExtD), .q(ImmExtE));
  pipe_reg #(.WIDTH(XLEN)) u_pc      (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                      .d(PCD), .q(PCE));
  pipe_reg #(.WIDTH(XLEN)) u_pc_plus4 (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                       .d(PCPlus4D), .q(PCPlus4E));

  // Register address fields
  pipe_reg #(.WIDTH(REG_ADDR_W)) u_rs1 (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                        .d(Rs1D), .q(Rs1E));
  pipe_reg #(.WIDTH(REG_ADDR_W)) u_rs2 (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                        .d(Rs2D), .q(Rs2E));
  pipe_reg #(.WIDTH(REG_ADDR_W)) u_rd  (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                        .d(RdD), .q(RdE));

  // Any non-flushed load means EX now holds a real instruction.
  pipe_reg #(.WIDTH(1)) u_valid (.clk(clk), .rst_n(rst_n), .en(ld_en), .clr(flush),
                                 .d(1'b1), .q(validE));

`ifdef ID_EX_PERF_CNT_EN
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

  // Counts every flush edge, stalled or not; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (flush) begin
      bubble_cnt_q <= bubble_cnt_q + BUBBLE_CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: expected E state is pushed when inputs are driven
// and popped/compared one edge later.
module tb_id_ex_reg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src_b;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [3:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } dvec_t;

  typedef struct packed {
    dvec_t       d;
    logic        valid;
    logic [31:0] cnt;
  } eout_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  dvec_t d_in = '0;

  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcBE;
  logic [1:0]  ResultSrcE, ALUSrcAE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [2:0]  funct3E;
  logic        validE;
  logic [31:0] bubble_cnt;

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .RegWriteD(d_in.reg_write), .MemWriteD(d_in.mem_write), .JumpD(d_in.jump),
    .BranchD(d_in.branch), .ALUSrcBD(d_in.alu_src_b), .ResultSrcD(d_in.result_src),
    .ALUSrcAD(d_in.alu_src_a), .ALUControlD(d_in.alu_ctrl),
    .RD1D(d_in.rd1), .RD2D(d_in.rd2), .ImmExtD(d_in.imm), .PCD(d_in.pc), .PCPlus4D(d_in.pcp4),
    .Rs1D(d_in.rs1), .Rs2D(d_in.rs2), .RdD(d_in.rd), .funct3D(d_in.funct3),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE), .ALUSrcAE(ALUSrcAE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .funct3E(funct3E),
    .validE(validE), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  eout_t obs;
  assign obs = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcBE, ResultSrcE, ALUSrcAE,
                ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, funct3E,
                validE, bubble_cnt};

  eout_t exp_q[$];
  dvec_t m_d     = '0;
  logic  m_valid = 1'b0;
  logic [31:0] m_cnt = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic dvec_t rand_d();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return dvec_t'(w[$bits(dvec_t)-1:0]);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_d     = '0;
    m_valid = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic compare(input string tag);
    eout_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".sb_depth"}, 256'(exp_q.size()), 256'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".fields"}, 256'(obs.d), 256'(e.d));
    check({tag, ".validE"}, 256'(obs.valid), 256'(e.valid));
    check({tag, ".bubble_cnt"}, 256'(obs.cnt), 256'(e.cnt));
  endtask

  // Drive one cycle at the falling edge, predict, then compare after the rising edge.
  task automatic drive(input string tag, input logic s, input logic f, input dvec_t d);
    eout_t e;
    @(negedge clk);
    stall = s;
    flush = f;
    d_in  = d;
    if (f) begin
      m_d     = '0;
      m_valid = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
      m_cnt   = m_cnt + 32'd1;
`endif
    end else if (!s) begin
      m_d     = d;
      m_valid = 1'b1;
    end
    e.d     = m_d;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    dvec_t lw, sw;

    // Async reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #1 check("rst_async", 256'(obs), 256'd0);
    // Reset held across an edge with live D inputs: nothing captured.
    d_in = rand_d();
    @(posedge clk);
    #1 check("rst_hold", 256'(obs), 256'd0);
    #3 rst_n = 1'b1;
    model_reset();

    // lw: x5 <- mem[x2 + 4]
    lw = '0;
    lw.reg_write  = 1'b1;
    lw.result_src = 2'b01;
    lw.alu_src_b  = 1'b1;
    lw.funct3     = 3'b010;
    lw.rd1        = 32'h0000_1000;
    lw.imm        = 32'h0000_0004;
    lw.rs1        = 5'd2;
    lw.rd         = 5'd5;
    lw.pc         = 32'h0000_0100;
    lw.pcp4       = 32'h0000_0104;
    drive("lw_pass", 1'b0, 1'b0, lw);
    check("lw_pass.RD1E", 256'(RD1E), 256'h1000);
    check("lw_pass.RdE", 256'(RdE), 256'd5);

    // Stall for 3 cycles while D changes: E frozen at lw.
    for (int i = 0; i < 3; i++) drive("stall", 1'b1, 1'b0, rand_d());
    check("stall.ImmExtE", 256'(ImmExtE), 256'h4);

    for (int i = 0; i < 6; i++) drive("pass", 1'b0, 1'b0, rand_d());

    // sw with flush and stall both high: flush wins.
    sw = '0;
    sw.mem_write = 1'b1;
    sw.alu_src_b = 1'b1;
    sw.funct3    = 3'b010;
    sw.rd1       = 32'h0000_2000;
    sw.rd2       = 32'hDEAD_BEEF;
    sw.imm       = 32'h0000_0008;
    sw.rs1       = 5'd3;
    sw.rs2       = 5'd7;
    sw.pc        = 32'h0000_0200;
    sw.pcp4      = 32'h0000_0204;
    drive("flush_stall", 1'b1, 1'b1, sw);
    check("flush_stall.MemWriteE", 256'(MemWriteE), 256'd0);
    drive("after_flush", 1'b0, 1'b0, sw);
    drive("flush_only", 1'b0, 1'b1, rand_d());

    // Mixed random traffic.
    for (int i = 0; i < 24; i++) begin
      drive("mix", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rand_d());
    end

    // Reset mid-cycle with a live instruction in EX.
    drive("pre_rst", 1'b0, 1'b0, lw);
    check("pre_rst.RegWriteE", 256'(RegWriteE), 256'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", 256'(obs), 256'd0);
    check("rst_mid.RegWriteE", 256'(RegWriteE), 256'd0);
    @(posedge clk);
    #1 check("rst_mid_edge", 256'(obs), 256'd0);
    #3 rst_n = 1'b1;
    model_reset();
    drive("post_rst", 1'b0, 1'b0, sw);
    drive("post_rst_flush", 1'b0, 1'b1, lw);

`ifdef ID_EX_PERF_CNT_EN
    // Counter wrap: preload near the top, then two flush edges.
    dut.bubble_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    drive("wrap1", 1'b0, 1'b1, rand_d());
    check("wrap1.cnt", 256'(bubble_cnt), 256'hFFFF_FFFF);
    drive("wrap2", 1'b1, 1'b1, rand_d());
    check("wrap2.cnt", 256'(bubble_cnt), 256'h0);
`else
    drive("nocnt", 1'b0, 1'b1, rand_d());
    check("nocnt.cnt", 256'(bubble_cnt), 256'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
